// File: rtl/if_stage_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch stage.
package if_stage_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned INST_LEN = 32;
    localparam int unsigned BUF_LEN  = 24;

    localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic {
        FETCH = 1'b0,
        READY = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: assembles a 32-bit little-endian word from four byte
// reads, presents it for one accepted cycle, then advances the PC by 4.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                jump_en,
    input  logic [ADDR_LEN-1:0] jump_target,
    input  logic                mem_ack,
    input  logic [7:0]          mem_rdata,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [ADDR_LEN-1:0] if_pc,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_stallreq
);

    if_state_e           state_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [1:0]          cnt_q;
    logic [BUF_LEN-1:0]  buf_q;
    logic [INST_LEN-1:0] inst_q;

    // Only stall[0] concerns this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    // Redirect outranks everything, including a same-cycle byte return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            inst_q  <= ZERO_WORD;
        end else if (jump_en) begin
            state_q <= FETCH;
            pc_q    <= jump_target;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ack) begin
                        case (cnt_q)
                            2'd0: buf_q[7:0]   <= mem_rdata;
                            2'd1: buf_q[15:8]  <= mem_rdata;
                            2'd2: buf_q[23:16] <= mem_rdata;
                            default: begin
                                inst_q  <= {mem_rdata, buf_q};
                                state_q <= READY;
                            end
                        endcase
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                READY: begin
                    if (!stall[0]) begin
                        pc_q    <= pc_q + ADDR_LEN'(4);
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Outputs decode from registered state only.
    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = pc_q + ADDR_LEN'(cnt_q);
    assign if_pc       = pc_q;
    assign if_inst     = (state_q == READY) ? inst_q : ZERO_WORD;
    assign if_stallreq = (state_q == FETCH);

endmodule

// File: tb/tb_if_stage.sv
// Fetch stage bench: byte-queue reference model, directed scenarios and
// randomized ack/stall/jump/reset traffic.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stallreq;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_target(jump_target),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_stallreq(if_stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Byte-addressed memory image; addresses 0..3 hold addi x1,x0,5.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h93;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return 8'((a * 32'd29) ^ (a >> 8) ^ 32'h5A);
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    always_comb mem_rdata = mem_byte(mem_addr);

    // Reference model: PC, queue of bytes gathered so far, presented word.
    logic [31:0] m_pc;
    logic [7:0]  m_bytes[$];
    bit          m_ready;
    logic [31:0] m_word;

    function automatic void model_reset();
        m_pc = 32'd0;
        m_bytes.delete();
        m_ready = 1'b0;
        m_word = 32'd0;
    endfunction

    function automatic void model_step(input logic st0, input logic jmp,
                                       input logic [31:0] tgt, input logic ack);
        if (jmp) begin
            m_pc = tgt;
            m_bytes.delete();
            m_ready = 1'b0;
        end else if (m_ready) begin
            if (!st0) begin
                m_pc = m_pc + 32'd4;
                m_ready = 1'b0;
            end
        end else if (ack) begin
            m_bytes.push_back(mem_byte(m_pc + 32'(m_bytes.size())));
            if (m_bytes.size() == 4) begin
                m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_bytes.delete();
                m_ready = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(!m_ready));
            chk("if_stallreq", 32'(if_stallreq), 32'(!m_ready));
            chk("if_pc", if_pc, m_pc);
            chk("if_inst", if_inst, m_ready ? m_word : 32'd0);
            if (!m_ready)
                chk("mem_addr", mem_addr, m_pc + 32'(m_bytes.size()));
        end
    end

    task automatic step(input logic st0, input logic jmp, input logic [31:0] tgt, input logic ack);
        stall       = {5'($urandom), st0};
        jump_en     = jmp;
        jump_target = tgt;
        mem_ack     = ack;
        @(posedge clk);
        model_step(st0, jmp, tgt, ack);
        #1;
        jump_en = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic acks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        stall = 6'd0;
        jump_en = 1'b0;
        jump_target = 32'd0;
        mem_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        chk_en = 1'b1;

        // First fetch from address 0, one byte per acked cycle.
        chk("first_addr", mem_addr, 32'd0);
        chk("first_req", 32'(mem_req), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("addr1", mem_addr, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("addr2", mem_addr, 32'd2);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("addr3", mem_addr, 32'd3);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("ready_inst", if_inst, 32'h0050_0093);
        chk("ready_pc", if_pc, 32'd0);
        chk("ready_stallreq", 32'(if_stallreq), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("next_addr", mem_addr, 32'd4);

        // Held presentation under stall[0].
        acks(4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b1);
            chk("stall_inst", if_inst, word_at(32'd4));
            chk("stall_pc", if_pc, 32'd4);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("after_stall_addr", mem_addr, 32'd8);

        // Redirect after two bytes, with a colliding ack.
        acks(2);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        chk("jump_addr", mem_addr, 32'h100);
        acks(4);
        chk("jump_inst", if_inst, word_at(32'h100));
        chk("jump_pc", if_pc, 32'h100);

        // Withheld ack at byte 1.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        acks(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            chk("wait_addr", mem_addr, 32'h105);
            chk("wait_stallreq", 32'(if_stallreq), 32'd1);
        end
        acks(3);
        chk("wait_inst", if_inst, word_at(32'h104));

        // PC wraps past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        acks(4);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("wrap_addr", mem_addr, 32'd0);

        // Reset mid-fetch discards the partial bytes.
        step(1'b0, 1'b1, 32'h40, 1'b0);
        acks(2);
        chk("pre_rst_addr", mem_addr, 32'h42);
        async_reset();
        chk("post_rst_addr", mem_addr, 32'd0);
        acks(4);
        chk("post_rst_inst", if_inst, 32'h0050_0093);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [31:0] tgt;
            r = $urandom_range(0, 299);
            case ($urandom_range(0, 2))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       tgt = 32'($urandom_range(0, 255));
                default: tgt = $urandom;
            endcase
            if (r == 0)
                async_reset();
            else
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), tgt,
                     1'($urandom_range(0, 9) < 7));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
